aes_decipher_block_p: RTL and testbench



---
 rtl/aes_decipher_block_p.sv | 192 +++++++++++++++++++
 tb/tb_aes_decipher_block_p.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decipher_block_p.sv
// Iterative AES-128/192/256 InvCipher round engine with NUM_SBOX inverse S-box word lanes per cycle.
// The external key memory returns round_key_i for the index presented on round_o.
module aes_decipher_block_p #(
  parameter int NUM_SBOX    = 1,
  parameter bit SUPPORT_192 = 1'b1
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         next_i,
  input  logic         abort_i,
  input  logic [1:0]   keylen_i,
  output logic         reset_round_o,
  output logic         new_round_o,
  output logic [3:0]   round_o,
  input  logic [127:0] round_key_i,
  input  logic [127:0] block_i,
  output logic [127:0] new_block_o,
  output logic         ready_o
);

  typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_e;

  localparam logic [1:0] CTR_STEP  = 2'(NUM_SBOX);
  localparam logic [1:0] LAST_GRP  = 2'(4 - NUM_SBOX);

  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4)) begin : g_bad_num_sbox
    $error("aes_decipher_block_p: NUM_SBOX must be 1, 2 or 4");
  end

  state_e           state_q, state_d;
  logic [3:0][31:0] st_q, st_d;
  logic [3:0]       round_q, round_d;
  logic             ready_q, ready_d;
  logic [1:0]       sword_ctr_q, sword_ctr_d;
  logic [3:0]       nr;
  logic [3:0][31:0] ark, imc;
  logic [1:0]       lane_idx;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), avoiding a 256-entry table per lane.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] a;
    a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
    return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // Column-major byte order; row r of the output takes column (c - r) mod 4 of the input.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    return {s[127:120], s[23:16],   s[47:40],   s[71:64],
            s[95:88],   s[119:112], s[15:8],    s[39:32],
            s[63:56],   s[87:80],   s[111:104], s[7:0],
            s[31:24],   s[55:48],   s[79:72],   s[103:96]};
  endfunction

  always_comb begin
    case (keylen_i)
      2'b01:   nr = SUPPORT_192 ? 4'd12 : 4'd10;
      2'b10:   nr = 4'd14;
      default: nr = 4'd10;
    endcase
  end

  assign ark = st_q ^ round_key_i;

  always_comb begin
    for (int c = 0; c < 4; c++) imc[c] = inv_mix_column(ark[c]);
  end

  always_comb begin
    state_d       = state_q;
    st_d          = st_q;
    round_d       = round_q;
    ready_d       = ready_q;
    sword_ctr_d   = sword_ctr_q;
    reset_round_o = 1'b0;
    new_round_o   = 1'b0;
    lane_idx      = 2'd0;
    case (state_q)
      IDLE: begin
        if (next_i && !abort_i) begin
          reset_round_o = 1'b1;
          round_d       = nr;
          ready_d       = 1'b0;
          state_d       = INIT;
        end
      end
      INIT: begin
        st_d        = inv_shift_rows(block_i ^ round_key_i);
        sword_ctr_d = 2'd0;
        state_d     = SBOX;
      end
      SBOX: begin
        // Word w lives at st[3-w], so the lane index is inverted to address it.
        for (int l = 0; l < NUM_SBOX; l++) begin
          lane_idx            = sword_ctr_q + 2'(l);
          st_d[~lane_idx]     = inv_sub_word(st_q[~lane_idx]);
        end
        sword_ctr_d = sword_ctr_q + CTR_STEP;
        if (sword_ctr_q == LAST_GRP) begin
          state_d = MAIN;
          if (round_q != 4'd0) begin
            new_round_o = 1'b1;
            round_d     = round_q - 4'd1;
          end
        end
      end
      MAIN: begin
        sword_ctr_d = 2'd0;
        if (round_q != 4'd0) begin
          st_d    = inv_shift_rows(imc);
          state_d = SBOX;
        end else begin
          st_d    = ark;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort discards whatever this cycle's round logic computed.
    if (state_q != IDLE && abort_i) begin
      state_d     = IDLE;
      st_d        = st_q;
      round_d     = round_q;
      ready_d     = 1'b1;
      sword_ctr_d = 2'd0;
      new_round_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      st_q        <= '0;
      round_q     <= 4'd0;
      ready_q     <= 1'b1;
      sword_ctr_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      round_q     <= round_d;
      ready_q     <= ready_d;
      sword_ctr_q <= sword_ctr_d;
    end
  end

  assign round_o     = round_q;
  assign new_block_o = st_q;
  assign ready_o     = ready_q;

endmodule

// File: tb/tb_aes_decipher_block_p.sv
// Bench for aes_decipher_block_p: four parameter variants share stimulus; expected plaintexts
// come from a forward AES cipher model and FIPS-197 vectors, latencies from the round formula.
module tb_aes_decipher_block_p;

  localparam int NS   [4] = '{1, 2, 4, 4};
  localparam bit S192 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         reset_n, next, abort;
  logic [1:0]   keylen;
  logic [127:0] blockIn;
  logic         rr [4];
  logic         nr [4];
  logic         rdy [4];
  logic [3:0]   rnd [4];
  logic [127:0] rk [4];
  logic [127:0] nb [4];
  logic [127:0] rkTab [15];
  logic [7:0]   sboxT [256];

  int passCount = 0;
  int checkCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  // Behavioural key memory: one per DUT, indexed by that DUT's round output.
  always_comb begin
    for (int k = 0; k < 4; k++) rk[k] = (rnd[k] <= 4'd14) ? rkTab[rnd[k]] : '0;
  end

  aes_decipher_block_p #(.NUM_SBOX(1), .SUPPORT_192(1'b1)) u_n1 (
    .clk_i(clk), .reset_n_i(reset_n), .next_i(next), .abort_i(abort), .keylen_i(keylen),
    .reset_round_o(rr[0]), .new_round_o(nr[0]), .round_o(rnd[0]), .round_key_i(rk[0]),
    .block_i(blockIn), .new_block_o(nb[0]), .ready_o(rdy[0]));
  aes_decipher_block_p #(.NUM_SBOX(2), .SUPPORT_192(1'b1)) u_n2 (
    .clk_i(clk), .reset_n_i(reset_n), .next_i(next), .abort_i(abort), .keylen_i(keylen),
    .reset_round_o(rr[1]), .new_round_o(nr[1]), .round_o(rnd[1]), .round_key_i(rk[1]),
    .block_i(blockIn), .new_block_o(nb[1]), .ready_o(rdy[1]));
  aes_decipher_block_p #(.NUM_SBOX(4), .SUPPORT_192(1'b1)) u_n4 (
    .clk_i(clk), .reset_n_i(reset_n), .next_i(next), .abort_i(abort), .keylen_i(keylen),
    .reset_round_o(rr[2]), .new_round_o(nr[2]), .round_o(rnd[2]), .round_key_i(rk[2]),
    .block_i(blockIn), .new_block_o(nb[2]), .ready_o(rdy[2]));
  aes_decipher_block_p #(.NUM_SBOX(4), .SUPPORT_192(1'b0)) u_n4_no192 (
    .clk_i(clk), .reset_n_i(reset_n), .next_i(next), .abort_i(abort), .keylen_i(keylen),
    .reset_round_o(rr[3]), .new_round_o(nr[3]), .round_o(rnd[3]), .round_key_i(rk[3]),
    .block_i(blockIn), .new_block_o(nb[3]), .ready_o(rdy[3]));

  // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sboxT[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sboxT[w[31:24]], sboxT[w[23:16]], sboxT[w[15:8]], sboxT[w[7:0]]};
  endfunction

  function automatic int modelNr(input logic [1:0] kl, input bit s192);
    if (kl == 2'b01) return s192 ? 12 : 10;
    if (kl == 2'b10) return 14;
    return 10;
  endfunction

  function automatic int modelNk(input logic [1:0] kl);
    if (kl == 2'b01) return 6;
    if (kl == 2'b10) return 8;
    return 4;
  endfunction

  function automatic int expLat(input int k, input logic [1:0] kl);
    return 1 + modelNr(kl, S192[k]) * (4 / NS[k] + 1);
  endfunction

  task automatic expandKey(input logic [255:0] key, input logic [1:0] kl);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk, nrr;
    nk = modelNk(kl);
    nrr = modelNr(kl, 1'b1);
    rcon = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nrr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subWord(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r < 15; r++)
      rkTab[r] = (r <= nrr) ? {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]} : '0;
  endtask

  // Forward cipher over the current schedule; the DUT must invert it.
  function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nrr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] out;
    for (int j = 0; j < 16; j++) s[j] = pt[127 - 8 * j -: 8] ^ rkTab[0][127 - 8 * j -: 8];
    for (int r = 1; r <= nrr; r++) begin
      for (int j = 0; j < 16; j++) s[j] = sboxT[s[j]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[4 * c + q] = s[4 * ((c + q) % 4) + q];
      if (r < nrr) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end
      end else begin
        for (int j = 0; j < 16; j++) s[j] = t[j];
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ rkTab[r][127 - 8 * j -: 8];
    end
    for (int j = 0; j < 16; j++) out[127 - 8 * j -: 8] = s[j];
    return out;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full operation; next held for 'hold' edges starting with the accepting edge.
  task automatic applyStimulus(input string tag, input logic [1:0] kl, input logic [127:0] ct,
                               input logic [127:0] pt, input int hold);
    int lat [4];
    bit seen [4];
    int nrCnt, nr0;
    bit seqOk;
    logic [3:0] prev;
    nr0 = modelNr(kl, 1'b1);
    nrCnt = 0;
    seqOk = 1'b1;
    prev = 4'd0;
    for (int k = 0; k < 4; k++) begin lat[k] = 0; seen[k] = 1'b0; end
    keylen = kl;
    blockIn = ct;
    next = 1'b1;
    #1;
    checkOutput({tag, "_reset_round"}, 128'(rr[0]), 128'd1);
    for (int e = 0; e <= 200; e++) begin
      @(posedge clk);
      #1;
      if (e + 1 >= hold) next = 1'b0;
      if (e == 0) begin
        checkOutput({tag, "_busy"}, 128'({rdy[0], rdy[1], rdy[2], rdy[3]}), 128'd0);
        checkOutput({tag, "_first_round"}, 128'(rnd[0]), 128'(nr0));
        prev = rnd[0];
      end else begin
        for (int k = 0; k < 4; k++)
          if (!seen[k] && rdy[k]) begin seen[k] = 1'b1; lat[k] = e; end
      end
      if (!seen[0]) begin
        if (rnd[0] != prev && rnd[0] != prev - 4'd1) seqOk = 1'b0;
        prev = rnd[0];
        if (nr[0]) nrCnt++;
      end
      if (seen[0] && seen[1] && seen[2] && seen[3]) break;
    end
    next = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("%s_latency%0d", tag, k), 128'(lat[k]), 128'(expLat(k, kl)));
      if (!(k == 3 && kl == 2'b01))
        checkOutput($sformatf("%s_plaintext%0d", tag, k), nb[k], pt);
    end
    checkOutput({tag, "_round_sequence"}, 128'(seqOk), 128'd1);
    checkOutput({tag, "_new_round_count"}, 128'(nrCnt), 128'(nr0));
    checkOutput({tag, "_final_round"}, 128'(rnd[0]), 128'd0);
  endtask

  initial begin
    logic [255:0] key;
    logic [127:0] pt, ct;
    logic [1:0]   kl;
    int           expRound;

    reset_n = 1'b0;
    next = 1'b0;
    abort = 1'b0;
    keylen = 2'b00;
    blockIn = '0;
    for (int r = 0; r < 15; r++) rkTab[r] = '0;
    buildSbox();

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("reset_new_block%0d", k), nb[k], 128'd0);
      checkOutput($sformatf("reset_round%0d", k), 128'(rnd[k]), 128'd0);
      checkOutput($sformatf("reset_ready%0d", k), 128'(rdy[k]), 128'd1);
    end
    checkOutput("reset_comb_outputs", 128'({rr[0], nr[0]}), 128'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_ready", 128'(rdy[0]), 128'd1);

    expandKey(K128, 2'b00);
    applyStimulus("c1", 2'b00, CT1, PT, 1);
    expandKey(K192, 2'b01);
    applyStimulus("c2", 2'b01, CT2, PT, 1);
    expandKey(K256, 2'b10);
    applyStimulus("c3", 2'b10, CT3, PT, 1);
    expandKey(K128, 2'b11);
    applyStimulus("kl11", 2'b11, CT1, PT, 1);
    applyStimulus("next_held", 2'b00, CT1, PT, 15);

    for (int i = 0; i < 4; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      kl = 2'($urandom_range(0, 3));
      expandKey(key, kl);
      ct = encrypt(pt, modelNr(kl, 1'b1));
      applyStimulus($sformatf("random%0d", i), kl, ct, pt, 1);
    end

    // Abort on the last S-box group of round 5 of the NUM_SBOX=1 engine.
    expandKey(K128, 2'b00);
    keylen = 2'b00;
    blockIn = CT1;
    next = 1'b1;
    @(posedge clk);
    #1;
    next = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    abort = 1'b1;
    #1;
    checkOutput("abort_new_round_suppressed", 128'(nr[0]), 128'd0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expRound = 10 - 29 / (4 / NS[k] + 1);
      if (expRound < 0) expRound = 0;
      checkOutput($sformatf("abort_ready%0d", k), 128'(rdy[k]), 128'd1);
      checkOutput($sformatf("abort_round%0d", k), 128'(rnd[k]), 128'(expRound));
    end
    checkOutput("abort_idle_result_kept", nb[2], PT);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_round_holds", 128'(rnd[0]), 128'd5);
    applyStimulus("post_abort", 2'b00, CT1, PT, 1);

    next = 1'b1;
    abort = 1'b1;
    #1;
    checkOutput("abort_blocks_next_pulse", 128'(rr[0]), 128'd0);
    @(posedge clk);
    #1;
    checkOutput("abort_blocks_next_ready", 128'(rdy[0]), 128'd1);
    checkOutput("abort_blocks_next_block", nb[0], PT);
    next = 1'b0;
    abort = 1'b0;

    // Asynchronous reset while the engines are in SBOX.
    next = 1'b1;
    @(posedge clk);
    #1;
    next = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("async_reset_block%0d", k), nb[k], 128'd0);
      checkOutput($sformatf("async_reset_ready%0d", k), 128'(rdy[k]), 128'd1);
      checkOutput($sformatf("async_reset_round%0d", k), 128'(rnd[k]), 128'd0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus("post_reset", 2'b00, CT1, PT, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
